player_move_ctrl: RTL and testbench

PLAYER_MOVE_CTRL -- requirements
Module: player_move_ctrl

---
 rtl/rpg_pkg.sv | 56 +++++
 rtl/player_damage_ctrl.sv | 64 ++++++
 rtl/player_move_ctrl.sv | 172 +++++++++++++++++
 tb/tb_player_move_ctrl.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rpg_pkg.sv
// -----------------------------------------------------------------------------
// rpg_pkg
// Shared definitions for the player movement / damage blocks:
//   - dir_t     : movement direction encoding (up, right, down, left)
//   - state_t   : movement FSM state type, with ST_* state constants
//   - playfield limits (X_MIN..X_MAX, Y_MIN..Y_MAX) and knockback distance
//   - pick_dir  : fixed-priority button resolver (up > right > down > left)
//   - clamp_coord: add a signed offset to a 10-bit coordinate and clamp it
// -----------------------------------------------------------------------------
package rpg_pkg;

    typedef enum logic [1:0] {
        DIR_UP    = 2'd0,
        DIR_RIGHT = 2'd1,
        DIR_DOWN  = 2'd2,
        DIR_LEFT  = 2'd3
    } dir_t;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE   = 2'd0;
    localparam state_t ST_LOOKUP = 2'd1;
    localparam state_t ST_WAIT   = 2'd2;
    localparam state_t ST_DECIDE = 2'd3;

    localparam int X_MIN        = 144;
    localparam int X_MAX        = 768;
    localparam int Y_MIN        = 31;
    localparam int Y_MAX        = 495;
    localparam int KNOCKBACK_PX = 8;

    // btn is {left, down, right, up}; the lowest set bit wins.
    function automatic dir_t pick_dir(input logic [3:0] btn);
        dir_t d;
        d = DIR_UP;
        if (btn[0])      d = DIR_UP;
        else if (btn[1]) d = DIR_RIGHT;
        else if (btn[2]) d = DIR_DOWN;
        else if (btn[3]) d = DIR_LEFT;
        return d;
    endfunction

    // Arithmetic is done in 32-bit signed so a step past either edge saturates
    // at the limit instead of wrapping the 10-bit coordinate.
    function automatic logic [9:0] clamp_coord(input logic [9:0] coord,
                                               input int         delta,
                                               input int         lo,
                                               input int         hi);
        int v;
        v = int'(coord) + delta;
        if (v < lo)      v = lo;
        else if (v > hi) v = hi;
        return v[9:0];
    endfunction

endpackage

// File: rtl/player_damage_ctrl.sv
// -----------------------------------------------------------------------------
// player_damage_ctrl
// Health and invulnerability bookkeeping for the player.
//   i_frame_tick    : one-cycle pulse per video frame
//   i_enemy_collide : player/enemy overlap (level)
//   o_damage_now    : combinational, high on the frame_tick edge that applies
//                     damage (lets the parent react on the same edge)
//   o_health        : remaining health
//   o_hit           : one-cycle pulse the cycle after damage is applied
//   o_dead          : high while health is zero
// -----------------------------------------------------------------------------
module player_damage_ctrl
    import rpg_pkg::*;
#(
    parameter int INVULN_FRAMES = 60,
    parameter int MAX_HEALTH    = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_frame_tick,
    input  logic       i_enemy_collide,
    output logic       o_damage_now,
    output logic [2:0] o_health,
    output logic       o_hit,
    output logic       o_dead
);

    localparam int CW = (INVULN_FRAMES > 1) ? $clog2(INVULN_FRAMES + 1) : 1;

    logic [CW-1:0] r_invuln;
    logic [CW-1:0] w_invuln_dec;
    logic [2:0]    r_health;
    logic          r_hit;

    assign w_invuln_dec = (r_invuln != '0) ? (r_invuln - CW'(1)) : '0;

    // The immunity window is judged on the already-decremented count, so a
    // fresh hit lands exactly INVULN_FRAMES frame ticks after the previous one.
    assign o_damage_now = i_frame_tick && i_enemy_collide &&
                          (w_invuln_dec == '0) && (r_health != 3'd0);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_invuln <= '0;
            r_health <= 3'(MAX_HEALTH);
            r_hit    <= 1'b0;
        end else begin
            r_hit <= o_damage_now;
            if (i_frame_tick) begin
                r_invuln <= o_damage_now ? CW'(INVULN_FRAMES) : w_invuln_dec;
            end
            if (o_damage_now) begin
                r_health <= r_health - 3'd1;
            end
        end
    end

    assign o_health = r_health;
    assign o_hit    = r_hit;
    assign o_dead   = (r_health == 3'd0);

endmodule

// File: rtl/player_move_ctrl.sv
// -----------------------------------------------------------------------------
// player_move_ctrl
// Tile-checked player movement with health / invulnerability tracking.
//   clk, rst_n          : system clock, asynchronous active-low reset
//   frame_tick          : one-cycle pulse per video frame
//   btn                 : {left, down, right, up} move request (level)
//   pblockposx1..y4     : tile indices of the up/right/down/left probe points
//   enemyCollide        : player/enemy overlap (level)
//   map_x, map_y        : tile-map lookup address
//   map_wall            : wall flag, valid one cycle after the address
//   position            : {x[19:10], y[9:0]} player top-left pixel
//   health, hit, dead   : from the player_damage_ctrl sub-module
// Optional feature: define KNOCKBACK_EN to push the player KNOCKBACK_PX pixels
// away from the last latched direction whenever damage is applied.
// -----------------------------------------------------------------------------
module player_move_ctrl
    import rpg_pkg::*;
#(
    parameter int          STEP          = 2,
    parameter logic [19:0] START_POS     = {10'd160, 10'd47},
    parameter int          INVULN_FRAMES = 60,
    parameter int          MAX_HEALTH    = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        frame_tick,
    input  logic [3:0]  btn,
    input  logic [5:0]  pblockposx1,
    input  logic [5:0]  pblockposy1,
    input  logic [5:0]  pblockposx2,
    input  logic [5:0]  pblockposy2,
    input  logic [5:0]  pblockposx3,
    input  logic [5:0]  pblockposy3,
    input  logic [5:0]  pblockposx4,
    input  logic [5:0]  pblockposy4,
    input  logic        enemyCollide,
    output logic [5:0]  map_x,
    output logic [5:0]  map_y,
    input  logic        map_wall,
    output logic [19:0] position,
    output logic [2:0]  health,
    output logic        hit,
    output logic        dead
);

`ifdef KNOCKBACK_EN
    localparam bit KB_ON = 1'b1;
`else
    localparam bit KB_ON = 1'b0;
`endif

    state_t     r_state;
    dir_t       r_dir;
    dir_t       w_req_dir;
    logic       w_start;
    logic [5:0] r_map_x;
    logic [5:0] r_map_y;
    logic [5:0] w_probe_x;
    logic [5:0] w_probe_y;
    logic [9:0] r_pos_x;
    logic [9:0] r_pos_y;
    logic [9:0] w_step_x;
    logic [9:0] w_step_y;
    logic [9:0] w_kb_x;
    logic [9:0] w_kb_y;
    logic       w_damage_now;
    logic       w_dead;

    player_damage_ctrl #(
        .INVULN_FRAMES (INVULN_FRAMES),
        .MAX_HEALTH    (MAX_HEALTH)
    ) u_damage (
        .clk             (clk),
        .rst_n           (rst_n),
        .i_frame_tick    (frame_tick),
        .i_enemy_collide (enemyCollide),
        .o_damage_now    (w_damage_now),
        .o_health        (health),
        .o_hit           (hit),
        .o_dead          (w_dead)
    );

    assign w_req_dir = pick_dir(btn);
    // dead is judged on pre-edge health: a fatal hit on the same tick still
    // lets that tick's move start.
    assign w_start   = (r_state == ST_IDLE) && frame_tick && (btn != 4'd0) && !w_dead;

    // NOTE: every always_comb output gets a default first, so no path leaves
    // a signal unassigned and no latch is inferred.
    always_comb begin
        w_probe_x = pblockposx1;
        w_probe_y = pblockposy1;
        case (w_req_dir)
            DIR_RIGHT: begin w_probe_x = pblockposx2; w_probe_y = pblockposy2; end
            DIR_DOWN:  begin w_probe_x = pblockposx3; w_probe_y = pblockposy3; end
            DIR_LEFT:  begin w_probe_x = pblockposx4; w_probe_y = pblockposy4; end
            default:   ;
        endcase
    end

    // Candidate position for the DECIDE cycle (one STEP along r_dir).
    always_comb begin
        w_step_x = r_pos_x;
        w_step_y = r_pos_y;
        case (r_dir)
            DIR_UP:    w_step_y = clamp_coord(r_pos_y, -STEP, Y_MIN, Y_MAX);
            DIR_RIGHT: w_step_x = clamp_coord(r_pos_x,  STEP, X_MIN, X_MAX);
            DIR_DOWN:  w_step_y = clamp_coord(r_pos_y,  STEP, Y_MIN, Y_MAX);
            default:   w_step_x = clamp_coord(r_pos_x, -STEP, X_MIN, X_MAX);
        endcase
    end

    // Knockback position: KNOCKBACK_PX opposite to the last latched direction.
    always_comb begin
        w_kb_x = r_pos_x;
        w_kb_y = r_pos_y;
        case (r_dir)
            DIR_UP:    w_kb_y = clamp_coord(r_pos_y,  KNOCKBACK_PX, Y_MIN, Y_MAX);
            DIR_RIGHT: w_kb_x = clamp_coord(r_pos_x, -KNOCKBACK_PX, X_MIN, X_MAX);
            DIR_DOWN:  w_kb_y = clamp_coord(r_pos_y, -KNOCKBACK_PX, Y_MIN, Y_MAX);
            default:   w_kb_x = clamp_coord(r_pos_x,  KNOCKBACK_PX, X_MIN, X_MAX);
        endcase
    end

    // The lookup address is registered on the IDLE->LOOKUP edge so it is on
    // the bus for the whole LOOKUP cycle and stays put through WAIT and DECIDE;
    // map_wall is therefore stable when DECIDE samples it.
    // NOTE: reset here only clears control and address registers; every
    // register in this design is a flop with a defined reset value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_dir   <= DIR_UP;
            r_map_x <= 6'd0;
            r_map_y <= 6'd0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_start) begin
                        r_state <= ST_LOOKUP;
                        r_dir   <= w_req_dir;
                        r_map_x <= w_probe_x;
                        r_map_y <= w_probe_y;
                    end
                end
                ST_LOOKUP: r_state <= ST_WAIT;
                ST_WAIT:   r_state <= ST_DECIDE;
                default:   r_state <= ST_IDLE;
            endcase
        end
    end

    // Knockback takes priority over a coinciding DECIDE step.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pos_x <= START_POS[19:10];
            r_pos_y <= START_POS[9:0];
        end else if (KB_ON && w_damage_now) begin
            r_pos_x <= w_kb_x;
            r_pos_y <= w_kb_y;
        end else if ((r_state == ST_DECIDE) && !map_wall) begin
            r_pos_x <= w_step_x;
            r_pos_y <= w_step_y;
        end
    end

    assign map_x    = r_map_x;
    assign map_y    = r_map_y;
    assign position = {r_pos_x, r_pos_y};
    assign dead     = w_dead;

endmodule

// File: tb/tb_player_move_ctrl.sv
// -----------------------------------------------------------------------------
// tb_player_move_ctrl
// Self-checking bench: a frame/cycle-level model of the player (scheduled move
// completion, frame-count based immunity) is compared with the DUT on every
// falling edge, plus literal expectations for the directed scenarios.
// A second instance (STEP=4, start x=146) covers the left-edge clamp.
// -----------------------------------------------------------------------------
module tb_player_move_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        frame_tick = 1'b0;
    logic [3:0]  btn = 4'd0;
    logic        enemyCollide = 1'b0;
    logic [5:0]  px [4];
    logic [5:0]  py [4];
    logic        map_wall = 1'b0;
    logic        map_wall2 = 1'b0;
    logic [5:0]  map_x, map_y, map_x2, map_y2;
    logic [19:0] position, position2;
    logic [2:0]  health, health2;
    logic        hit, hit2, dead, dead2;

    int n_tests = 0;
    int n_fail  = 0;
    int hit_cnt = 0;
    int wall_mode = 1;     // 0: hashed map, 1: no walls, 2: all walls
    bit checking = 1'b0;

    always #5 clk = ~clk;

    player_move_ctrl dut (
        .clk(clk), .rst_n(rst_n), .frame_tick(frame_tick), .btn(btn),
        .pblockposx1(px[0]), .pblockposy1(py[0]), .pblockposx2(px[1]), .pblockposy2(py[1]),
        .pblockposx3(px[2]), .pblockposy3(py[2]), .pblockposx4(px[3]), .pblockposy4(py[3]),
        .enemyCollide(enemyCollide), .map_x(map_x), .map_y(map_y), .map_wall(map_wall),
        .position(position), .health(health), .hit(hit), .dead(dead)
    );

    player_move_ctrl #(.STEP(4), .START_POS({10'd146, 10'd47})) dut2 (
        .clk(clk), .rst_n(rst_n), .frame_tick(frame_tick), .btn(btn),
        .pblockposx1(px[0]), .pblockposy1(py[0]), .pblockposx2(px[1]), .pblockposy2(py[1]),
        .pblockposx3(px[2]), .pblockposy3(py[2]), .pblockposx4(px[3]), .pblockposy4(py[3]),
        .enemyCollide(enemyCollide), .map_x(map_x2), .map_y(map_y2), .map_wall(map_wall2),
        .position(position2), .health(health2), .hit(hit2), .dead(dead2)
    );

    function automatic logic wall_fn(input logic [5:0] x, input logic [5:0] y);
        int v;
        if (wall_mode == 1) return 1'b0;
        if (wall_mode == 2) return 1'b1;
        v = int'(x) * 5 + int'(y) * 3;
        return (v % 4) == 0;
    endfunction

    // Tile memory: one-cycle read latency.
    always @(posedge clk) begin
        map_wall  <= wall_fn(map_x, map_y);
        map_wall2 <= wall_fn(map_x2, map_y2);
    end

    function automatic int clampi(input int v, input int lo, input int hi);
        if (v < lo) return lo;
        if (v > hi) return hi;
        return v;
    endfunction

    task automatic check(input string name, input longint act, input longint exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
        end
    endtask

    // ---------------- behavioural model (default parameters) ----------------
    int m_x, m_y, m_health, m_busy, m_mapx, m_mapy, m_frames, m_last_hit;
    int m_dir, m_last_dir;
    bit m_hit;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_x = 160; m_y = 47; m_health = 3; m_busy = 0;
            m_mapx = 0; m_mapy = 0; m_frames = 0; m_last_hit = -1000000;
            m_hit = 1'b0; m_dir = 0; m_last_dir = 0;
        end else begin
            bit dmg, accepted, was_dead;
            int nx, ny;
            was_dead = (m_health == 0);
            dmg = 1'b0;
            accepted = 1'b0;
            if (frame_tick) begin
                m_frames++;
                if (enemyCollide && m_health > 0 && (m_frames - m_last_hit) >= 60) begin
                    dmg = 1'b1;
                    m_health--;
                    m_last_hit = m_frames;
                end
            end
            m_hit = dmg;
            nx = m_x; ny = m_y;
            if (m_busy > 0) begin
                // Move completes on the third edge after it was accepted.
                if (m_busy == 1 && !wall_fn(6'(m_mapx), 6'(m_mapy))) begin
                    case (m_dir)
                        0: ny = clampi(m_y - 2, 31, 495);
                        1: nx = clampi(m_x + 2, 144, 768);
                        2: ny = clampi(m_y + 2, 31, 495);
                        default: nx = clampi(m_x - 2, 144, 768);
                    endcase
                end
                m_busy--;
            end else if (frame_tick && btn != 4'd0 && !was_dead) begin
                for (int i = 3; i >= 0; i--) if (btn[i]) m_dir = i;
                m_mapx = int'(px[m_dir]);
                m_mapy = int'(py[m_dir]);
                m_busy = 3;
                accepted = 1'b1;
            end
`ifdef KNOCKBACK_EN
            if (dmg) begin
                nx = m_x; ny = m_y;
                case (m_last_dir)
                    0: ny = clampi(m_y + 8, 31, 495);
                    1: nx = clampi(m_x - 8, 144, 768);
                    2: ny = clampi(m_y - 8, 31, 495);
                    default: nx = clampi(m_x + 8, 144, 768);
                endcase
            end
`endif
            m_x = nx; m_y = ny;
            if (accepted) m_last_dir = m_dir;
        end
    end

    always @(negedge clk) begin
        if (checking) begin
            check("pos_x",  position[19:10], m_x);
            check("pos_y",  position[9:0],   m_y);
            check("health", health,          m_health);
            check("hit",    hit,             m_hit);
            check("dead",   dead,            m_health == 0);
            check("map_x",  map_x,           m_mapx);
            check("map_y",  map_y,           m_mapy);
        end
        if (hit) hit_cnt++;
    end

    // ---------------- stimulus helpers ----------------
    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic tick();
        frame_tick = 1'b1;
        step(1);
        frame_tick = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step(2);
        rst_n = 1'b1;
        step(1);
    endtask

    initial begin
        int kb_exp;
        for (int k = 0; k < 4; k++) begin
            px[k] = 6'(5 + 4 * k);
            py[k] = 6'(40 + 3 * k);
        end
        step(1);
        do_reset();
        checking = 1'b1;

        // Reset state
        check("rst_pos", position, {10'd160, 10'd47});
        check("rst_health", health, 3);
        check("rst_hit", hit, 0);
        check("rst_dead", dead, 0);
        check("rst_map", {map_x, map_y}, 0);

        // Up move, free tile: y 47 -> 45 exactly three edges after the tick
        wall_mode = 1;
        btn = 4'b0001;
        tick();
        btn = 4'b0000;
        check("up_lookup_map_x", map_x, 5);
        check("up_lookup_map_y", map_y, 40);
        check("up_e0_y", position[9:0], 47);
        step(1);
        check("up_e1_y", position[9:0], 47);
        step(1);
        check("up_e2_y", position[9:0], 47);
        step(1);
        check("up_e3_y", position[9:0], 45);

        // Right move into a wall: no change, FSM idle again right after DECIDE
        wall_mode = 2;
        btn = 4'b0010;
        tick();
        check("right_map_x", map_x, 9);
        step(2);
        btn = 4'b0100;
        tick();
        check("wall_pos", position, {10'd160, 10'd45});
        tick();
        check("idle_again_map_x", map_x, 13);
        btn = 4'b0000;
        step(3);
        check("wall_down_pos", position, {10'd160, 10'd45});

        // All buttons: up serviced only; tick during WAIT ignored
        wall_mode = 1;
        btn = 4'b1111;
        tick();
        step(1);
        frame_tick = 1'b1;
        step(1);
        frame_tick = 1'b0;
        step(1);
        check("prio_pos", position, {10'd160, 10'd43});
        step(4);
        check("ignored_tick_pos", position, {10'd160, 10'd43});
        btn = 4'b0000;

        // Continuous collision: hits at frames 1, 61, 121, then dead
        do_reset();
        hit_cnt = 0;
        enemyCollide = 1'b1;
        for (int f = 1; f <= 130; f++) begin
            tick();
            if (f == 1)   begin check("f1_health", health, 2); check("f1_hit", hit, 1); end
            if (f == 2)   check("f2_hit", hit, 0);
            if (f == 60)  check("f60_health", health, 2);
            if (f == 61)  check("f61_health", health, 1);
            if (f == 120) check("f120_health", health, 1);
            if (f == 121) begin check("f121_health", health, 0); check("f121_dead", dead, 1); end
            step(2);
        end
        check("hit_pulses", hit_cnt, 3);
        check("dead_final", dead, 1);
        enemyCollide = 1'b0;
        btn = 4'b0001;
        tick();
        step(4);
        check("dead_frozen_pos", position, {10'd160, 10'd47});
        check("dead_health", health, 0);
        btn = 4'b0000;

        // STEP=4 instance starting at x=146: left move clamps to 144
        do_reset();
        btn = 4'b1000;
        tick();
        btn = 4'b0000;
        step(3);
        check("clamp_x_step4", position2[19:10], 144);
        check("clamp_y_step4", position2[9:0], 47);

        // Hit after a right move: knockback only when the feature is built in
        do_reset();
        btn = 4'b0010;
        tick();
        btn = 4'b0000;
        step(3);
        check("right_x", position[19:10], 162);
        enemyCollide = 1'b1;
        tick();
        enemyCollide = 1'b0;
`ifdef KNOCKBACK_EN
        kb_exp = 154;
`else
        kb_exp = 162;
`endif
        check("hit_pos_x", position[19:10], kb_exp);
        check("hit_pulse", hit, 1);
        step(2);

        // Randomized traffic against the model, with occasional mid-move resets
        wall_mode = 0;
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            frame_tick   = ($urandom_range(0, 2) == 0);
            btn          = ($urandom_range(0, 3) == 0) ? 4'd0 : 4'($urandom);
            enemyCollide = ($urandom_range(0, 15) == 0);
            for (int k = 0; k < 4; k++) begin
                px[k] = 6'($urandom);
                py[k] = 6'($urandom);
            end
            if ((c % 400) == 399) begin
                rst_n = 1'b0;
                step(2);
                rst_n = 1'b1;
            end
            step(1);
        end
        frame_tick = 1'b0;
        btn = 4'd0;
        enemyCollide = 1'b0;
        step(5);

        checking = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
